// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU: opcode encoding, flag bit
// positions, the control FSM states and a helper that packs the flag vector.
// No ports; imported by alu_comb_core and alu_pipe.
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_OR       = 4'd0,
    OP_AND      = 4'd1,
    OP_NAND     = 4'd2,
    OP_NOR      = 4'd3,
    OP_NOT      = 4'd4,
    OP_XOR      = 4'd5,
    OP_ADD      = 4'd6,
    OP_SUB      = 4'd7,
    OP_SHL      = 4'd8,
    OP_SHR      = 4'd9,
    OP_CMP      = 4'd10,
    OP_ROL      = 4'd11,
    OP_ROR      = 4'd12,
    OP_SRA      = 4'd13,
    OP_MUL      = 4'd14,
    OP_RESERVED = 4'd15
  } op_e;

  // Bit positions inside the 4-bit flag vector {overflow, carry, neg, zero}.
  localparam int unsigned ZF = 0;
  localparam int unsigned NF = 1;
  localparam int unsigned CF = 2;
  localparam int unsigned VF = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

  // Assembles the flag vector so every producer uses the same bit order.
  function automatic logic [3:0] make_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f     = 4'b0000;
    f[VF] = v;
    f[CF] = c;
    f[NF] = n;
    f[ZF] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// -----------------------------------------------------------------------------
// alu_comb_core
// Purely combinational result/flag generation for every single-cycle opcode.
// MUL and the reserved opcode yield y=0 here; the wrapper decides how they
// are handled.
// Ports:
//   a_i, b_i  [WIDTH]  operands (b_i is also the shift/rotate amount)
//   op_i      op_e     opcode
//   y_o       [WIDTH]  result
//   flags_o   [4]      {overflow, carry, neg, zero}
// -----------------------------------------------------------------------------
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] y_o,
  output logic [3:0]       flags_o
);

  localparam int LOG = $clog2(WIDTH);
  localparam logic [LOG:0] W_AMT = WIDTH[LOG:0];

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] diff_s;
  logic             big_s;
  logic [LOG-1:0]   amt_s;
  logic [LOG:0]     amt_inv_s;
  logic [WIDTH-1:0] sra_s;
  logic [WIDTH-1:0] y_s;
  logic             c_s;
  logic             v_s;
  logic             n_en_s;

  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_s = a_i - b_i;
  // WIDTH is a power of two, so b >= WIDTH exactly when any bit above the
  // low LOG bits is set.
  assign big_s     = |b_i[WIDTH-1:LOG];
  assign amt_s     = b_i[LOG-1:0];
  // Complementary rotate amount; a shift by WIDTH yields zero, so amount 0
  // still rotates correctly.
  assign amt_inv_s = W_AMT - {1'b0, amt_s};
  assign sra_s     = $signed(a_i) >>> amt_s;

  // Result and flag selection for all single-cycle opcodes.
  always_comb begin
    y_s    = {WIDTH{1'b0}};
    c_s    = 1'b0;
    v_s    = 1'b0;
    n_en_s = 1'b0;
    case (op_i)
      OP_OR:   y_s = a_i | b_i;
      OP_AND:  y_s = a_i & b_i;
      OP_NAND: y_s = ~(a_i & b_i);
      OP_NOR:  y_s = ~(a_i | b_i);
      OP_NOT:  y_s = ~a_i;
      OP_XOR:  y_s = a_i ^ b_i;
      OP_ADD: begin
        y_s    = sum_s[WIDTH-1:0];
        c_s    = sum_s[WIDTH];
        v_s    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
        n_en_s = 1'b1;
      end
      OP_SUB: begin
        y_s    = diff_s;
        c_s    = (a_i < b_i);
        v_s    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_s[WIDTH-1] != a_i[WIDTH-1]);
        n_en_s = 1'b1;
      end
      OP_SHL: begin
        y_s    = big_s ? {WIDTH{1'b0}} : (a_i << amt_s);
        n_en_s = 1'b1;
      end
      OP_SHR: begin
        y_s    = big_s ? {WIDTH{1'b0}} : (a_i >> amt_s);
        n_en_s = 1'b1;
      end
      OP_SRA: begin
        y_s    = big_s ? {WIDTH{a_i[WIDTH-1]}} : sra_s;
        n_en_s = 1'b1;
      end
      OP_CMP: begin
        if (a_i == b_i) begin
          y_s = {WIDTH{1'b0}};
        end else if (a_i > b_i) begin
          y_s = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          y_s = {WIDTH{1'b1}};
        end
      end
      OP_ROL:  y_s = (a_i << amt_s) | (a_i >> amt_inv_s);
      OP_ROR:  y_s = (a_i >> amt_s) | (a_i << amt_inv_s);
      default: y_s = {WIDTH{1'b0}};
    endcase
  end

  assign y_o     = y_s;
  assign flags_o = make_flags(v_s, c_s, n_en_s & y_s[WIDTH-1], (y_s == {WIDTH{1'b0}}));

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Registered ALU between operand fetch and writeback. Operands arrive on a
// valid/ready handshake; the result, flags and illegal indication leave from
// an output register that holds under backpressure. MUL is an iterative
// shift-add multiplier taking WIDTH cycles in MUL_BUSY.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake
//   a, b [WIDTH]        operands; b is also the shift/rotate amount
//   op [4]              opcode (alu_pkg::op_e encoding)
//   out_valid/out_ready result handshake
//   y [WIDTH]           result
//   flags [4]           {overflow, carry, neg, zero}
//   illegal             result came from an unimplemented opcode
// -----------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       flags_q, flags_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  op_e              op_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             is_illegal_s;
  logic [WIDTH-1:0] core_y_s;
  logic [3:0]       core_flags_s;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] acc_sum_s;

  assign op_s         = op_e'(op);
  assign in_ready     = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_s     = in_valid && in_ready;
  assign is_mul_s     = MUL_EN && (op_s == OP_MUL);
  assign is_illegal_s = (op_s == OP_RESERVED) || ((op_s == OP_MUL) && !MUL_EN);

  assign addend_s  = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
  assign acc_sum_s = acc_q + addend_s;

  alu_comb_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i     (a),
    .b_i     (b),
    .op_i    (op_s),
    .y_o     (core_y_s),
    .flags_o (core_flags_s)
  );

  // Next-state logic: FSM, output register loads and multiplier steps.
  always_comb begin
    state_d     = state_q;
    // A presented result retires when the consumer takes it.
    out_valid_d = out_valid_q && !out_ready;
    y_d         = y_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (is_mul_s) begin
            state_d  = MUL_BUSY;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = {WIDTH{1'b0}};
            cnt_d    = {CW{1'b0}};
          end else if (is_illegal_s) begin
            y_d         = {WIDTH{1'b0}};
            flags_d     = make_flags(1'b0, 1'b0, 1'b0, 1'b1);
            illegal_d   = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            y_d         = core_y_s;
            flags_d     = core_flags_s;
            illegal_d   = 1'b0;
            out_valid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL_BUSY: begin
        acc_d    = acc_sum_s;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        // The output register is free here: accepting the MUL retired any
        // earlier result, so completion never overwrites a held value.
        if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          y_d         = acc_sum_s;
          flags_d     = make_flags(1'b0, 1'b0, acc_sum_s[WIDTH-1],
                                   (acc_sum_s == {WIDTH{1'b0}}));
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          state_d = MUL_BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, output and multiplier registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      y_q         <= {WIDTH{1'b0}};
      flags_q     <= 4'b0000;
      illegal_q   <= 1'b0;
      mcand_q     <= {WIDTH{1'b0}};
      mplier_q    <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Three instances (WIDTH=32/MUL_EN=1, WIDTH=8/MUL_EN=0, WIDTH=64/MUL_EN=1),
// each with its own driver, reference model, expected-result queue and
// monitor. Directed corner cases come first, then randomized traffic with
// random backpressure.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int w,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (W=%0d) got=%0h want=%0h", name, w, act, exp);
    end
  endtask

  function automatic int cfg_w(input int i);
    case (i)
      0:       return 32;
      1:       return 8;
      default: return 64;
    endcase
  endfunction

  function automatic bit cfg_m(input int i);
    return (i == 1) ? 1'b0 : 1'b1;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int W  = cfg_w(gi);
    localparam bit ME = cfg_m(gi);

    logic         rst_n, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [W-1:0] a, b, y;
    logic [3:0]   op, flags;
    bit           done = 1'b0;

    logic [W-1:0] qy[$];
    logic [3:0]   qf[$];
    logic         qi[$];

    alu_pipe #(.WIDTH(W), .MUL_EN(ME)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .flags     (flags),
      .illegal   (illegal)
    );

    // Reference model: plain wide arithmetic on the operand values.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] z, output logic [W-1:0] r,
                                  output logic [3:0] f, output logic il);
      logic signed [129:0] sx, sz, ss, lim;
      logic [129:0]        wide;
      bit                  c, v, n_on;
      int                  amt;
      sx = $signed(x);
      sz = $signed(z);
      lim = 130'sd1 <<< (W - 1);
      r = '0; c = 0; v = 0; n_on = 0; il = 0;
      case (o)
        4'd0: r = x | z;
        4'd1: r = x & z;
        4'd2: r = ~(x & z);
        4'd3: r = ~(x | z);
        4'd4: r = ~x;
        4'd5: r = x ^ z;
        4'd6: begin
          wide = 130'(x) + 130'(z);
          r = wide[W-1:0];
          c = (wide >> W) != 0;
          ss = sx + sz;
          v = (ss >= lim) || (ss < -lim);
          n_on = 1;
        end
        4'd7: begin
          r = x - z;
          c = (x < z);
          ss = sx - sz;
          v = (ss >= lim) || (ss < -lim);
          n_on = 1;
        end
        4'd8:  begin r = (z >= W) ? '0 : (x << z); n_on = 1; end
        4'd9:  begin r = (z >= W) ? '0 : (x >> z); n_on = 1; end
        4'd13: begin
          amt = (z >= W) ? W : int'(z);
          ss = sx >>> amt;
          r = ss[W-1:0];
          n_on = 1;
        end
        4'd10: r = (x == z) ? '0 : ((x > z) ? W'(1) : '1);
        4'd11: begin amt = int'(z % W); r = (x << amt) | (x >> (W - amt)); end
        4'd12: begin amt = int'(z % W); r = (x >> amt) | (x << (W - amt)); end
        4'd14: begin
          if (ME) begin
            wide = 130'(x) * 130'(z);
            r = wide[W-1:0];
            n_on = 1;
          end else begin
            il = 1;
          end
        end
        default: il = 1;
      endcase
      if (il) begin r = '0; c = 0; v = 0; n_on = 0; end
      f = {v, c, n_on && r[W-1], r == '0};
    endfunction

    function automatic logic [W-1:0] rnd_w();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[W-1:0];
    endfunction

    // One cycle of stimulus; an accepted operation pushes its expectation.
    task automatic drive(input bit v, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] z, input bit ordy, output bit acc);
      logic [W-1:0] ey;
      logic [3:0]   ef;
      logic         ei;
      @(negedge clk);
      in_valid = v; op = o; a = x; b = z; out_ready = ordy;
      #1;
      acc = v && in_ready;
      if (acc) begin
        model(o, x, z, ey, ef, ei);
        qy.push_back(ey); qf.push_back(ef); qi.push_back(ei);
      end
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] z, input bit rnd_ready);
      bit acc;
      acc = 0;
      for (int k = 0; k < 300 && !acc; k++)
        drive(1'b1, o, x, z, rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1, acc);
      if (!acc) chk("issue_timeout", W, 0, 1);
    endtask

    task automatic idle(input int n);
      bit acc;
      for (int k = 0; k < n; k++) drive(1'b0, 4'd0, '0, '0, 1'b1, acc);
    endtask

    task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      qy.delete(); qf.delete(); qi.delete();
      #1;
      chk("rst_out_valid", W, out_valid, 0);
      chk("rst_y", W, y, 0);
      chk("rst_flags", W, flags, 0);
      chk("rst_illegal", W, illegal, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", W, in_ready, 1);
      chk("rst_out_valid_after", W, out_valid, 0);
    endtask

    // MUL: in_ready low for W cycles, result visible on the cycle after.
    task automatic mul_latency(input logic [W-1:0] x, input logic [W-1:0] z);
      bit acc;
      int first, bad_ready;
      first = 0; bad_ready = 0;
      issue(4'd14, x, z, 1'b0);
      for (int k = 1; k <= W + 4 && first == 0; k++) begin
        drive(1'b0, 4'd0, '0, '0, 1'b1, acc);
        if (out_valid) first = k;
        else if (in_ready) bad_ready++;
      end
      chk("mul_latency", W, first, W + 1);
      chk("mul_busy_ready", W, bad_ready, 0);
    endtask

    // Driver.
    initial begin
      logic [W-1:0] ones, msb, x, z;
      bit acc;
      ones = '1;
      msb = {1'b1, {(W-1){1'b0}}};
      rst_n = 1'b1; in_valid = 1'b0; op = 4'd0; a = '0; b = '0; out_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("init_out_valid", W, out_valid, 0);
      chk("init_y", W, y, 0);
      chk("init_flags", W, flags, 0);
      chk("init_in_ready", W, in_ready, 1);
      rst_n = 1'b1;

      // Directed corner cases.
      issue(4'd6, ones, W'(1), 1'b0);
      idle(1);
      chk("add_latency", W, out_valid, 1);
      issue(4'd7, msb, W'(1), 1'b0);
      issue(4'd7, W'(3), W'(5), 1'b0);
      issue(4'd9, msb, W'(W + 8), 1'b0);
      issue(4'd13, msb, W'(W + 8), 1'b0);
      issue(4'd12, W'(1), W'(W + 1), 1'b0);
      issue(4'd8, W'(1), W'(W), 1'b0);
      issue(4'd8, W'(1), W'(W - 1), 1'b0);
      issue(4'd11, msb | W'(1), W'(W + 1), 1'b0);
      issue(4'd10, W'(5), W'(5), 1'b0);
      issue(4'd10, W'(6), W'(5), 1'b0);
      issue(4'd10, W'(5), W'(6), 1'b0);
      issue(4'd4, ones, W'(7), 1'b0);
      issue(4'd15, W'(7), W'(9), 1'b0);
      if (ME) begin
        mul_latency(W'(12345), W'(678));
        mul_latency(ones, ones);
        issue(4'd14, W'(99), W'(77), 1'b0);
        idle(10);
        do_reset();
      end else begin
        issue(4'd14, W'(12), W'(34), 1'b0);
        idle(1);
        chk("illegal_latency", W, out_valid, 1);
      end

      // Reset while a result is held under backpressure.
      issue(4'd1, W'(6), W'(3), 1'b0);
      for (int k = 0; k < 3; k++) drive(1'b0, 4'd0, '0, '0, 1'b0, acc);
      do_reset();

      // Backpressure then same-edge handoff.
      idle(W + 3);
      x = rnd_w(); z = rnd_w();
      issue(4'd1, x, z, 1'b0);
      for (int k = 0; k < 5; k++) begin
        drive(1'b1, 4'd5, z, x, 1'b0, acc);
        chk("bp_no_accept", W, acc, 0);
      end
      drive(1'b1, 4'd5, z, x, 1'b1, acc);
      chk("bp_handoff_accept", W, acc, 1);
      drive(1'b0, 4'd0, '0, '0, 1'b1, acc);
      chk("bp_no_bubble", W, out_valid, 1);

      // Randomized traffic.
      for (int n = 0; n < 250; n++) begin
        x = rnd_w();
        case ($urandom_range(0, 2))
          0:       z = rnd_w();
          1:       z = W'($urandom_range(0, W + 3));
          default: z = msb | W'($urandom_range(0, 3));
        endcase
        if ($urandom_range(0, 4) == 0) x = msb;
        issue(4'($urandom_range(0, 15)), x, z, 1'b1);
        if ($urandom_range(0, 4) == 0) idle(1);
      end
      idle(W + 10);
      chk("queue_drained", W, qy.size(), 0);
      done = 1'b1;
    end

    // Monitor: hold checks under backpressure, scoreboard compare on transfer.
    bit           held = 1'b0;
    logic [W-1:0] hy, ey;
    logic [3:0]   hf, ef;
    logic         hi, ei;
    always begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", W, out_valid, 1);
          chk("hold_y", W, y, hy);
          chk("hold_flags", W, flags, hf);
          chk("hold_illegal", W, illegal, hi);
        end
        if (out_valid && !out_ready) begin
          chk("hold_in_ready", W, in_ready, 0);
          held = 1'b1; hy = y; hf = flags; hi = illegal;
        end else begin
          held = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (qy.size() == 0) begin
            chk("unexpected_output", W, 1, 0);
          end else begin
            ey = qy.pop_front(); ef = qf.pop_front(); ei = qi.pop_front();
            chk("result_y", W, y, ey);
            chk("result_flags", W, flags, ef);
            chk("result_illegal", W, illegal, ei);
          end
        end
      end
    end
  end

  // Summary once every configuration has finished or the time budget expires.
  initial begin
    for (int c = 0; c < 60000 &&
         !(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done); c++)
      @(posedge clk);
    if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done))
      chk("global_timeout", 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
